// File: rtl/bht_predictor.sv
// Branch history table predictor with saturating counters, global history and hit statistics.
// Optional gshare indexing (pc XOR history) selected by macro BHT_PREDICTOR_GSHARE_EN.
module bht_predictor #(
  parameter int TABLE_ADR_WIDTH = 4,
  parameter int CTR_WIDTH       = 2,
  parameter int HIST_WIDTH      = 4,
  parameter int STAT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [6:0]            opcode,
  input  logic [2:0]            pcSource,
  input  logic [31:0]           pc,
  output logic                  ready,
  output logic                  predict_taken,
  output logic [STAT_WIDTH-1:0] total_branches,
  output logic [STAT_WIDTH-1:0] correct_static,
  output logic [STAT_WIDTH-1:0] correct_dynamic
);

  localparam int DEPTH = 1 << TABLE_ADR_WIDTH;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [CTR_WIDTH-1:0] CTR_WNT  = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);
  localparam logic [TABLE_ADR_WIDTH-1:0] PTR_LAST = '1;
  localparam logic [TABLE_ADR_WIDTH-1:0] PTR_ONE  = TABLE_ADR_WIDTH'(1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                     state_q, state_d;
  logic [TABLE_ADR_WIDTH-1:0] ptr_q, ptr_d;
  logic [HIST_WIDTH-1:0]      hist_q;
  logic [CTR_WIDTH-1:0]       bht_mem [DEPTH];
  logic [TABLE_ADR_WIDTH-1:0] idx;
  logic [CTR_WIDTH-1:0]       ctr_cur, ctr_next;
  logic                       branch_evt, taken;
  logic                       unused_pc;

  // Only the word-aligned index bits of pc take part in prediction.
  assign unused_pc = ^{pc[31:TABLE_ADR_WIDTH+2], pc[1:0]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + PTR_ONE;
      if (ptr_q == PTR_LAST) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ready      = (state_q == RUN);
  assign branch_evt = data_valid && (opcode == OP_BRANCH) && ready;
  assign taken      = (pcSource == 3'd2);

`ifdef BHT_PREDICTOR_GSHARE_EN
  assign idx = pc[TABLE_ADR_WIDTH+1:2] ^ TABLE_ADR_WIDTH'(hist_q);
`else
  assign idx = pc[TABLE_ADR_WIDTH+1:2];
`endif

  assign ctr_cur       = bht_mem[idx];
  assign predict_taken = branch_evt && ctr_cur[CTR_WIDTH-1];

  always_comb begin
    ctr_next = ctr_cur;
    if (taken) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_ONE;
    end else begin
      if (ctr_cur != CTR_MIN) ctr_next = ctr_cur - CTR_ONE;
    end
  end

  // Table has no reset of its own; the INIT sweep clears it after every rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) bht_mem[ptr_q] <= CTR_WNT;
      else if (branch_evt) bht_mem[idx]   <= ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q          <= '0;
      total_branches  <= '0;
      correct_static  <= '0;
      correct_dynamic <= '0;
    end else if (branch_evt) begin
      hist_q <= HIST_WIDTH'({hist_q, taken});
      if (total_branches != STAT_MAX) total_branches <= total_branches + STAT_ONE;
      if (taken && (correct_static != STAT_MAX)) correct_static <= correct_static + STAT_ONE;
      if ((predict_taken == taken) && (correct_dynamic != STAT_MAX))
        correct_dynamic <= correct_dynamic + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: a default instance plus a STAT_WIDTH=4 instance on shared inputs.
module tb_bht_predictor;

  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  pc_source = 3'd0;
  logic [31:0] pc = 32'd0;

  logic        ready, predict_taken;
  logic [31:0] total_branches, correct_static, correct_dynamic;
  logic        ready_s, predict_s;
  logic [3:0]  total_s, static_s, dynamic_s;

  int checks = 0;
  int failures = 0;
  int n;

  bht_predictor dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .opcode(opcode),
    .pcSource(pc_source), .pc(pc), .ready(ready), .predict_taken(predict_taken),
    .total_branches(total_branches), .correct_static(correct_static),
    .correct_dynamic(correct_dynamic)
  );

  bht_predictor #(.STAT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .data_valid(data_valid), .opcode(opcode),
    .pcSource(pc_source), .pc(pc), .ready(ready_s), .predict_taken(predict_s),
    .total_branches(total_s), .correct_static(static_s),
    .correct_dynamic(dynamic_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 100) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic br(input string tag, input logic [31:0] a, input logic tk, input logic exp_p);
    data_valid = 1'b1;
    opcode     = OP_BR;
    pc         = a;
    pc_source  = tk ? 3'd2 : 3'd0;
    #1;
    check(tag, {31'd0, predict_taken}, {31'd0, exp_p});
    check({tag, "_s"}, {31'd0, predict_s}, {31'd0, exp_p});
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_pred", {31'd0, predict_taken}, 32'd0);
    check("rst_total", total_branches, 32'd0);
    check("rst_static", correct_static, 32'd0);
    check("rst_dyn", correct_dynamic, 32'd0);

    // Count INIT cycles; inject taken branches at pc=0x40 during cycles 4..6.
    n = 0;
    while (!ready && n < 100) begin
      if (n >= 3 && n < 6) begin
        data_valid = 1'b1; opcode = OP_BR; pc = 32'h40; pc_source = 3'd2;
        #1 check("init_pred", {31'd0, predict_taken}, 32'd0);
      end
      @(posedge clk);
      #1 data_valid = 1'b0;
      n++;
    end
    check("init_cycles", n, 32'd16);
    check("init_total", total_branches, 32'd0);
    check("init_static", correct_static, 32'd0);
    check("init_dyn", correct_dynamic, 32'd0);

    br("t4_0", 32'h40, 1'b1, 1'b0);
    br("t4_1", 32'h40, 1'b1, 1'b1);
    br("t4_2", 32'h40, 1'b1, 1'b1);
    br("t4_3", 32'h40, 1'b1, 1'b1);
    check("t4_total", total_branches, 32'd4);
    check("t4_static", correct_static, 32'd4);
    check("t4_dyn", correct_dynamic, 32'd3);

    do_reset();
    wait_ready(n);
    check("rerun_cycles", n, 32'd16);
    br("tn_0", 32'h40, 1'b1, 1'b0);
    br("tn_1", 32'h40, 1'b1, 1'b1);
    br("tn_2", 32'h40, 1'b1, 1'b1);
    br("tn_3", 32'h40, 1'b0, 1'b1);
    check("tn_total", total_branches, 32'd4);
    check("tn_static", correct_static, 32'd3);
    check("tn_dyn", correct_dynamic, 32'd2);

    data_valid = 1'b1; opcode = OP_ALU; pc = 32'h40; pc_source = 3'd2;
    #1 check("alu_pred", {31'd0, predict_taken}, 32'd0);
    @(posedge clk);
    #1 data_valid = 1'b0;
    check("alu_total", total_branches, 32'd4);

    br("dec_hold", 32'h40, 1'b1, 1'b1);
    br("lo_0", 32'h44, 1'b0, 1'b0);
    br("lo_1", 32'h44, 1'b0, 1'b0);
    br("lo_2", 32'h44, 1'b1, 1'b0);
    br("lo_3", 32'h44, 1'b1, 1'b0);
    br("lo_4", 32'h44, 1'b1, 1'b1);

    // Reset again 8 cycles into the sweep: sweep restarts from index 0.
    do_reset();
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("mid_ready", {31'd0, ready}, 32'd0);
    do_reset();
    wait_ready(n);
    check("mid_cycles", n, 32'd16);
    check("mid_ready_s", {31'd0, ready_s}, 32'd1);
    check("mid_total", total_branches, 32'd0);

    br("hist_0", 32'h0, 1'b1, 1'b0);
`ifdef BHT_PREDICTOR_GSHARE_EN
    br("hist_1", 32'h0, 1'b1, 1'b0);
`else
    br("hist_1", 32'h0, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 20; i++) begin
      data_valid = 1'b1; opcode = OP_BR; pc = 32'h80; pc_source = 3'd2;
      @(posedge clk);
      #1;
    end
    data_valid = 1'b0;
    check("sat_total", total_branches, 32'd22);
    check("sat_total_s", {28'd0, total_s}, 32'd15);
    check("sat_static_s", {28'd0, static_s}, 32'd15);
    check("sat_dyn_s_le", {31'd0, (dynamic_s <= 4'd15) && (dynamic_s >= 4'd13)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
